// File: rtl/noise_injector.sv
// noise_injector: adds gain-scaled CLT noise to the echo stream with saturation and frame-length checking.
// Optional NOISE_INJ_STATS_EN adds per-frame noise power outputs (stat_pwr, stat_valid).
module noise_injector #(
    parameter int DATA_W    = 16,
    parameter int NOISE_W   = 5,
    parameter int GAIN_W    = 8,
    parameter int FRAME_LEN = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [NOISE_W-1:0] noise_in,
    input  logic        [GAIN_W-1:0]  noise_gain,
    input  logic                      noise_en,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [DATA_W-1:0]  s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [DATA_W-1:0]  m_data,
    output logic                      m_last,
    output logic                      m_sat,
    output logic                      len_err
`ifdef NOISE_INJ_STATS_EN
    ,
    output logic [31:0]               stat_pwr,
    output logic                      stat_valid
`endif
);
    localparam int PW = NOISE_W + GAIN_W + 1;
    localparam int SW = DATA_W + 1;
    localparam int CW = $clog2(FRAME_LEN) + 1;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [GAIN_W-1:0]        gain_q, gain_d;
    logic                     inj_q, inj_d;
    logic                     v1_q, v1_d, l1_q, l1_d;
    logic signed [DATA_W-1:0] d1_q, d1_d;
    logic signed [PW-1:0]     p1_q, p1_d;
    logic                     mv_q, mv_d, ml_q, ml_d, ms_q, ms_d, err_q, err_d;
    logic signed [DATA_W-1:0] md_q, md_d;

    logic                     adv, acc, idle, inj_use, at_end, fin, bad, ovf;
    logic [GAIN_W-1:0]        gain_use;
    logic signed [PW-1:0]     nz_x, g_x, prod;
    logic signed [SW-1:0]     sum;

`ifdef NOISE_INJ_STATS_EN
    logic [31:0]              pacc_q, pacc_d, pwr_q, pwr_d;
    logic                     sv_q, sv_d;
    logic [2*PW-1:0]          sq;
    logic [32:0]              tot;
    logic [31:0]              tot_sat;
`endif

    assign s_ready = adv && !rst;
    assign m_valid = mv_q;
    assign m_data  = md_q;
    assign m_last  = ml_q;
    assign m_sat   = ms_q;
    assign len_err = err_q;
`ifdef NOISE_INJ_STATS_EN
    assign stat_pwr   = pwr_q;
    assign stat_valid = sv_q;
`endif

    always_comb begin
        adv      = !mv_q || m_ready;
        acc      = s_valid && s_ready;
        idle     = state_q == IDLE;
        // The beat that opens a frame must already use the gain/enable it latches.
        gain_use = idle ? noise_gain : gain_q;
        inj_use  = idle ? noise_en : inj_q;
        nz_x     = PW'(noise_in);
        g_x      = PW'($signed({1'b0, gain_use}));
        prod     = inj_use ? nz_x * g_x : '0;
        at_end   = !idle && cnt_q == CW'(FRAME_LEN - 1);
        fin      = s_last || at_end;
        bad      = idle ? s_last : (s_last != at_end);
        sum      = SW'(d1_q) + SW'(p1_q);
        ovf      = sum[SW-1] != sum[SW-2];
        state_d  = state_q;
        cnt_d    = cnt_q;
        gain_d   = gain_q;
        inj_d    = inj_q;
        err_d    = err_q;
        v1_d     = v1_q;
        d1_d     = d1_q;
        p1_d     = p1_q;
        l1_d     = l1_q;
        mv_d     = mv_q;
        md_d     = md_q;
        ml_d     = ml_q;
        ms_d     = ms_q;
        if (acc) begin
            gain_d  = gain_use;
            inj_d   = inj_use;
            state_d = fin ? IDLE : FRAME;
            cnt_d   = fin ? '0 : (idle ? CW'(1) : cnt_q + CW'(1));
            err_d   = err_q || bad;
        end
        if (adv) begin
            v1_d = acc;
            d1_d = s_data;
            p1_d = prod;
            l1_d = fin;
            mv_d = v1_q;
            md_d = ovf ? (sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                       : sum[DATA_W-1:0];
            ml_d = l1_q;
            ms_d = ovf;
        end
`ifdef NOISE_INJ_STATS_EN
        sq      = (2*PW)'(p1_q) * (2*PW)'(p1_q);
        tot     = {1'b0, pacc_q} + 33'(sq);
        tot_sat = tot[32] ? '1 : tot[31:0];
        pacc_d  = pacc_q;
        pwr_d   = pwr_q;
        sv_d    = 1'b0;
        if (adv && v1_q) begin
            pacc_d = l1_q ? '0 : tot_sat;
            pwr_d  = l1_q ? tot_sat : pwr_q;
            sv_d   = l1_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gain_q  <= '0;
            inj_q   <= 1'b0;
            err_q   <= 1'b0;
            v1_q    <= 1'b0;
            d1_q    <= '0;
            p1_q    <= '0;
            l1_q    <= 1'b0;
            mv_q    <= 1'b0;
            md_q    <= '0;
            ml_q    <= 1'b0;
            ms_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gain_q  <= gain_d;
            inj_q   <= inj_d;
            err_q   <= err_d;
            v1_q    <= v1_d;
            d1_q    <= d1_d;
            p1_q    <= p1_d;
            l1_q    <= l1_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            ml_q    <= ml_d;
            ms_q    <= ms_d;
        end
    end

`ifdef NOISE_INJ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pacc_q <= '0;
            pwr_q  <= '0;
            sv_q   <= 1'b0;
        end else begin
            pacc_q <= pacc_d;
            pwr_q  <= pwr_d;
            sv_q   <= sv_d;
        end
    end
`endif
endmodule

// File: tb/tb_noise_injector.sv
// tb_noise_injector: directed and randomized checks of noise_injector against a beat-level reference model.
module tb_noise_injector;
    localparam int FL = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [4:0]  noise_in = '0;
    logic        [7:0]  noise_gain = '0;
    logic               noise_en = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic               s_last = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] m_data;
    logic               m_last, m_sat, len_err;

    noise_injector #(.DATA_W(16), .NOISE_W(5), .GAIN_W(8), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .noise_in(noise_in), .noise_gain(noise_gain), .noise_en(noise_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_sat(m_sat),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, tx_beat = 0;
    bit m_idle = 1, m_en = 0, m_err = 0, stalled = 0;
    int m_idx = 0, m_gain = 0, st_d = 0;
    int exp_d[$], acc_cyc[$], out_d[$], lat[$];
    bit exp_s[$], exp_l[$], out_s[$], out_l[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int d, input int nz, input int g, input bit en, input bit lst);
        int p, s;
        bit fl;
        if (m_idle) begin
            m_gain = g;
            m_en   = en;
            m_idx  = 1;
        end else m_idx++;
        fl     = lst || m_idx == FL;
        m_err  = m_err | (lst != (m_idx == FL));
        m_idle = fl;
        tx_beat = fl ? 0 : m_idx;
        p = m_en ? nz * m_gain : 0;
        s = d + p;
        exp_s.push_back(s > 32767 || s < -32768);
        exp_d.push_back(s > 32767 ? 32767 : (s < -32768 ? -32768 : s));
        exp_l.push_back(fl);
        acc_cyc.push_back(cyc);
    endtask

    task automatic step(input bit v, input int d, input int lst, input int nz, input int g,
                        input bit en, input bit mr);
        @(negedge clk);
        s_valid    = v;
        s_data     = 16'(d);
        s_last     = lst < 0 ? (tx_beat == FL - 1) : lst[0];
        noise_in   = 5'(nz);
        noise_gain = 8'(g);
        noise_en   = en;
        m_ready    = mr;
        #1;
        cyc++;
        check("s_ready_rule", s_ready, !m_valid || m_ready);
        check("len_err", len_err, m_err);
        if (stalled) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, st_d);
        end
        if (m_valid && m_ready) begin
            if (exp_d.size() == 0) check("spurious_out", exp_d.size(), 1);
            else begin
                check("out_data", m_data, exp_d.pop_front());
                check("out_sat", m_sat, exp_s.pop_front());
                check("out_last", m_last, exp_l.pop_front());
                out_d.push_back(m_data);
                out_s.push_back(m_sat);
                out_l.push_back(m_last);
                lat.push_back(cyc - acc_cyc.pop_front());
            end
        end
        stalled = m_valid && !m_ready;
        st_d    = m_data;
        if (s_valid && s_ready) model_accept(d, nz, g, en, s_last);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic frame(input int d, input int nz, input int g, input bit en);
        for (int i = 0; i < FL; i++) step(1, d, -1, nz, g, en, 1);
    endtask

    task automatic clr_logs();
        out_d.delete();
        out_s.delete();
        out_l.delete();
        lat.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_len_err", len_err, 0);
        m_idle = 1;
        m_err  = 0;
        tx_beat = 0;
        stalled = 0;
        exp_d.delete();
        exp_s.delete();
        exp_l.delete();
        acc_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("init_m_valid", m_valid, 0);
        check("init_m_data", m_data, 0);
        check("init_m_last", m_last, 0);
        check("init_m_sat", m_sat, 0);
        check("init_len_err", len_err, 0);
        check("init_s_ready", s_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        clr_logs();
        frame(100, 6, 255, 0);
        flush(2);
        check("pt_count", out_d.size(), 4);
        check("pt_data", out_d[0], 100);
        check("pt_sat", out_s[0], 0);
        check("pt_latency", lat[0], 2);

        clr_logs();
        frame(100, -3, 4, 1);
        flush(2);
        check("add_data", out_d[0], 88);
        check("add_last_beat3", out_l[2], 0);
        check("add_last_beat4", out_l[3], 1);
        check("add_len_err", len_err, 0);

        clr_logs();
        frame(32767, 6, 255, 1);
        frame(-32768, -6, 10, 1);
        flush(2);
        check("sat_hi_data", out_d[0], 32767);
        check("sat_hi_flag", out_s[0], 1);
        check("sat_lo_data", out_d[4], -32768);
        check("sat_lo_flag", out_s[4], 1);

        clr_logs();
        step(1, 10, -1, 1, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 20 + i, -1, 1, 1, 1, 0);
        check("bp_s_ready", s_ready, 0);
        for (int i = 0; i < 20 && tx_beat != 0; i++) step(1, 40 + i, -1, 1, 1, 1, 1);
        flush(3);
        check("bp_count", out_d.size(), 4);
        check("bp_first", out_d[0], 11);
        check("bp_second", out_d[1], 21);

        clr_logs();
        step(1, 100, -1, -3, 4, 1, 1);
        step(1, 100, -1, -3, 4, 1, 1);
        step(1, 100, -1, -3, 8, 1, 1);
        step(1, 100, -1, -3, 8, 1, 1);
        frame(100, -3, 8, 1);
        flush(2);
        check("gain_mid_frame", out_d[3], 88);
        check("gain_next_frame", out_d[4], 76);

        clr_logs();
        step(1, 5, 0, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0, 0, 1);
        flush(2);
        check("short_last", out_l[1], 1);
        check("short_len_err", len_err, 1);
        flush(1);
        check("short_sticky", len_err, 1);

        step(1, 1, -1, 2, 3, 1, 1);
        step(1, 2, -1, 2, 3, 1, 1);
        do_reset();
        clr_logs();
        frame(50, 1, 2, 1);
        flush(2);
        check("rst_frame_last3", out_l[2], 0);
        check("rst_frame_last4", out_l[3], 1);
        check("rst_frame_err", len_err, 0);

        clr_logs();
        for (int i = 0; i < FL; i++) step(1, 7, 0, 1, 1, 0, 1);
        flush(2);
        check("forced_last", out_l[3], 1);
        check("forced_len_err", len_err, 1);
        frame(9, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 800; i++)
            step($urandom_range(3) != 0, $urandom_range(65535) - 32768,
                 ($urandom_range(9) == 0) ? int'($urandom_range(1)) : -1,
                 $urandom_range(12) - 6, $urandom_range(255), $urandom_range(1) == 1,
                 $urandom_range(3) != 0);
        flush(4);
        check("drain_empty", exp_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
